lsu_sram_ctrl: RTL

// - Load/store unit for the single-cycle RV32I core, SRAM build.
// - Executes the memory requests raised by the decoder: o_mem_rden/o_mem_wren, funct3 size and ALU address.
// - Drives a req/ack SRAM port and stalls the core (PC and regfile writes held) until the access completes.
// - Returns aligned, sign/zero-extended load data on the writeback path.

---
 rtl/rv32i_pkg.sv | 22 ++
 rtl/lsu_sram_ctrl_if.sv | 13 +
 rtl/lsu_data_align.sv | 74 +++++++
 rtl/lsu_sram_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and LSU state type.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_DONE} lsu_state_e;

  // Stores have no unsigned variants, so their legal set is narrower.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_sram_ctrl_if.sv
// Word-wide SRAM req/ack port between the LSU (master) and the memory (slave).
interface lsu_sram_ctrl_if #(parameter int ADDR_W = 16) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        bmask;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, bmask, input rdata, ack);
  modport slave  (input req, we, addr, wdata, bmask, output rdata, ack);
endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane steering: alignment check, store lane replication/bmask,
// load byte/half select with sign or zero extension.
module lsu_data_align
  import rv32i_pkg::*;
(
  input  logic        rden,
  input  logic        wren,
  input  logic [2:0]  req_f3,
  input  logic [1:0]  req_off,
  output logic        misaligned,
  input  logic        we,
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  bmask,
  output logic [31:0] ld_data
);
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // f3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    misaligned = 1'b0;
    if (rden && wren) misaligned = 1'b1;
    else if (rden || wren) begin
      if (!f3_legal(req_f3, wren)) misaligned = 1'b1;
      else begin
        case (req_f3[1:0])
          2'b01:   misaligned = req_off[0];
          2'b10:   misaligned = |req_off;
          default: misaligned = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    wdata = st_data;
    bmask = 4'b1111;
    if (we) begin
      case (f3[1:0])
        2'b00: begin
          bmask = 4'b0001 << off;
          wdata = {4{st_data[7:0]}};
        end
        2'b01: begin
          bmask = off[1] ? 4'b1100 : 4'b0011;
          wdata = {2{st_data[15:0]}};
        end
        default: begin
          bmask = 4'b1111;
          wdata = st_data;
        end
      endcase
    end
  end

  assign ld_b = rdata[{off, 3'b000} +: 8];
  assign ld_h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = '0;
    case (f3)
      F3_LB:   ld_data = {{24{ld_b[7]}}, ld_b};
      F3_LH:   ld_data = {{16{ld_h[15]}}, ld_h};
      F3_LW:   ld_data = rdata;
      F3_LBU:  ld_data = {24'd0, ld_b};
      F3_LHU:  ld_data = {16'd0, ld_h};
      default: ld_data = '0;
    endcase
  end
endmodule

// File: rtl/lsu_sram_ctrl.sv
// Load/store unit for the single-cycle RV32I core: stalls the core while a
// single SRAM req/ack access is in flight, with an ack timeout.
module lsu_sram_ctrl
  import rv32i_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_rden,
  input  logic        i_mem_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_err,
  lsu_sram_ctrl_if.master sram
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W+1:0] cap_addr;
  logic [2:0]        cap_f3;
  logic [31:0]       cap_st, cap_rdata;
  logic              cap_we;
  logic              mis_raw, stall_c, timeout_hit, in_req;
  logic [31:0]       al_wdata, al_ld;
  logic [3:0]        al_bmask;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^i_addr[31:ADDR_W+2];

  lsu_data_align u_align (
    .rden       (i_mem_rden),
    .wren       (i_mem_wren),
    .req_f3     (i_funct3),
    .req_off    (i_addr[1:0]),
    .misaligned (mis_raw),
    .we         (cap_we),
    .f3         (cap_f3),
    .off        (cap_addr[1:0]),
    .st_data    (cap_st),
    .rdata      (cap_rdata),
    .wdata      (al_wdata),
    .bmask      (al_bmask),
    .ld_data    (al_ld)
  );

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    nxt       = state;
    stall_c   = 1'b0;
    o_bus_err = 1'b0;
    case (state)
      LSU_IDLE: if ((i_mem_rden || i_mem_wren) && !mis_raw) begin
        stall_c = 1'b1;
        nxt     = LSU_REQ;
      end
      LSU_REQ: begin
        stall_c = 1'b1;
        if (sram.ack) nxt = LSU_DONE;
        else if (timeout_hit) begin
          o_bus_err = 1'b1;
          nxt       = LSU_DONE;
        end
      end
      // DONE ignores the still-asserted request of the committing instruction.
      LSU_DONE: nxt = LSU_IDLE;
      default:  nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= LSU_IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_f3    <= '0;
      cap_st    <= '0;
      cap_we    <= 1'b0;
      cap_rdata <= '0;
    end else begin
      state <= nxt;
      if (state == LSU_IDLE && nxt == LSU_REQ) begin
        cap_addr <= i_addr[ADDR_W+1:0];
        cap_f3   <= i_funct3;
        cap_st   <= i_st_data;
        cap_we   <= i_mem_wren;
      end
      if (state == LSU_REQ && nxt == LSU_REQ) cnt <= cnt + CNT_W'(1);
      else                                    cnt <= '0;
      // A timed-out access returns zero as its read data.
      if (state == LSU_REQ && nxt == LSU_DONE)
        cap_rdata <= sram.ack ? sram.rdata : '0;
    end
  end

  // Reset gates the combinational outputs so a held request reads as idle.
  assign o_stall      = stall_c && i_rst_n;
  assign o_misaligned = (state == LSU_IDLE) && mis_raw && i_rst_n;
  assign o_ld_data    = (state == LSU_DONE && !cap_we) ? al_ld : '0;

  assign in_req      = (state == LSU_REQ);
  assign sram.req    = in_req;
  assign sram.we     = in_req && cap_we;
  assign sram.addr   = in_req ? cap_addr[ADDR_W+1:2] : '0;
  assign sram.wdata  = in_req ? al_wdata : '0;
  assign sram.bmask  = in_req ? al_bmask : '0;
endmodule
